// File: rtl/uart_word_tx.sv
// ----------------------------------------------------------------------------
// uart_word_tx
//
// Sends one NBYTES*8-bit word over an 8N1 UART line as NBYTES framed bytes.
// Byte 0 (data[7:0]) goes first and each byte is sent LSB first, so the line
// carries data bits 0..W-1 in order, each byte wrapped in a 0 start bit and a
// 1 stop bit. The next start bit follows a stop bit immediately.
//
// Parameters
//   CLK_DIV : clock cycles per serial bit (2..65535)
//   NBYTES  : bytes per word (4 in this design)
//
// Ports
//   clk    in   system clock, rising edge
//   RST    in   synchronous active-high reset; aborts any frame in flight
//   start  in   transmit request, only honoured in IDLE
//   data   in   word to send, latched on the accepting edge
//   TX     out  registered serial line, idle high
//   busy   out  high from the cycle after acceptance until the last stop ends
//   done   out  one-cycle pulse when the whole word has been sent
// ----------------------------------------------------------------------------
module uart_word_tx #(
    parameter int unsigned CLK_DIV = 5208,
    parameter int unsigned NBYTES  = 4
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   data,
    output logic                  TX,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [15:0]   BAUD_LAST = 16'(CLK_DIV - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     baud_q,  baud_d;
    logic [2:0]      bit_q,   bit_d;
    logic [BW-1:0]   byte_q,  byte_d;
    logic [W-1:0]    shreg_q, shreg_d;
    logic            tx_q,    tx_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;

    // End of the current bit period; every non-idle state lasts CLK_DIV cycles.
    logic baud_end;
    assign baud_end = (baud_q == BAUD_LAST);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shreg_d = shreg_q;

        // Baud counter runs freely in every framed state and wraps to 0 at
        // each bit boundary, which is also every state change.
        if (state_q != S_IDLE) begin
            baud_d = baud_end ? 16'd0 : baud_q + 16'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                baud_d = 16'd0;
                if (start) begin
                    state_d = S_START;
                    shreg_d = data;
                    bit_d   = 3'd0;
                    byte_d  = '0;
                end
            end

            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (baud_end) begin
                    // Shift after every bit, including the 8th, so the next
                    // byte is already at bit 0 when its data phase begins.
                    shreg_d = shreg_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end

            S_STOP: begin
                if (baud_end) begin
                    if (byte_q < BYTE_LAST) begin
                        byte_d  = byte_q + BW'(1);
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic: outputs are registered from the next state so TX only
    // moves on bit boundaries and never glitches.
    // ------------------------------------------------------------------------
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_STOP) && (state_d == S_IDLE);

        unique case (state_d)
            S_IDLE:  tx_d = 1'b1;
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shreg_d[0];
            S_STOP:  tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    assign TX   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Serial transmitter that sends one 32-bit word to the Arduino over an 8N1 UART line, as four framed bytes. It is the outbound counterpart of the tag-reading receiver. The controller uses it to push dispensing commands (compartment, dose count) to the Arduino. A single `start` pulse launches the frame; `busy` and `done` report progress back to the controller FSM.

## Interface
- `CLK_DIV`, default 5208: clock cycles per serial bit (50 MHz / 9600 baud); legal range 2..65535.
- `NBYTES`, default 4: bytes sent per word; fixed at 4 for this design (word width = 8*NBYTES = 32).

- `clk`  input  1  system clock; all logic on rising edge.
- `RST`  input  1  synchronous, active-high reset.
- `start`  input  1  request to transmit `data`; sampled on each rising edge.
- `data`  input  32  word to send; latched when `start` is accepted.
- `TX`  output  1  serial line to the Arduino; idle high.
- `busy`  output  1  high from the cycle after acceptance until the last stop bit ends.
- `done`  output  1  one-cycle pulse when the whole word has been sent.

## Operation
- Reset values: `TX`=1, `busy`=0, `done`=0, state IDLE, all counters 0, shift register 0.
- States:
  - **IDLE**: `TX`=1.
  - **START**: `TX`=0.
  - **DATA**: `TX` = current data bit.
  - **STOP**: `TX`=1.
- IDLE -> START when `start`=1:
  - latch `data` into a 32-bit shift register;
  - clear the bit counter (0..7) and the byte counter (0..NBYTES-1);
  - `busy`=1 from the next cycle.
- `start` is ignored in any state other than IDLE. There is no queuing; a `data` change while busy has no effect.
- Every state except IDLE lasts exactly `CLK_DIV` cycles, counted by a 16-bit baud counter that runs 0..CLK_DIV-1. The counter reloads to 0 on every state change and every bit advance.
- START -> DATA after `CLK_DIV` cycles.
- DATA:
  - sends 8 bits, LSB first;
  - shifts the register right by 1 per bit.
- DATA -> STOP after the 8th bit period.
- STOP, at the end of its period:
  - if byte counter < NBYTES-1: increment it and go to START;
  - else: go to IDLE, drop `busy` and pulse `done` for 1 cycle.
- Byte order:
  - byte 0 = `data[7:0]` is sent first, then `data[15:8]`, `data[23:16]`, `data[31:24]`;
  - the line therefore carries `data` bits in order 0..31, with each byte framed.
- There is no inter-byte gap: the next start bit follows the stop bit immediately.
- Reset mid-frame: on the edge where `RST`=1 the block aborts the frame. From the following cycle `TX`=1, `busy`=0 and `done`=0; no `done` pulse is generated for the aborted word.
- `RST` and `start` high in the same cycle: reset wins; the request is dropped.

## Timing
- `start` accepted at edge N. Then:
  - from N+1: `TX`=0 and `busy`=1;
  - the first data bit appears on `TX` at N+1+CLK_DIV.
- Each byte takes 10*CLK_DIV cycles; the whole word takes 40*CLK_DIV cycles (N+1 .. N+40*CLK_DIV).
- At cycle N+1+40*CLK_DIV: `done`=1 for exactly one cycle, `busy`=0, `TX`=1, state IDLE.
- Back-to-back: `start` is accepted in the `done` cycle. A new start bit then begins at N+2+40*CLK_DIV, leaving exactly 1 idle-high cycle between words.
- `TX` is a registered output, glitch-free, and changes only on bit boundaries.

## Test plan
- **Reset values:** `RST`=1 for 3 cycles, then release with `start`=0 -> `TX`=1, `busy`=0, `done`=0 held for 100 cycles.
- **Single word** (CLK_DIV=4): `start` pulse with `data`=32'hA5C3_0F81 -> the line carries byte 0x81 first (bits 1,0,0,0,0,0,0,1), then 0x0F, 0xC3, 0xA5. Each byte is framed 0-start / 1-stop, every bit lasts 4 cycles, `done` pulses at cycle 161 after acceptance, and `busy` is high for 160 cycles.
- **Start while busy:** during byte 2, `start`=1 with `data`=32'hFFFF_FFFF -> the original word completes unchanged, only one `done` pulse occurs, and the block returns to IDLE.
- **Back-to-back:** `start` held high continuously with `data` 32'h0000_0000 then 32'h1234_5678 -> exactly one idle cycle between words, the second word is decoded correctly by a bench UART model, and there are two `done` pulses 161 cycles apart.
- **Reset mid-frame:** `RST`=1 for 1 cycle during byte 1, data bit 3 -> from the next cycle `TX`=1 and `busy`=0, with no `done`. A subsequent `start` with 32'h0000_00FF sends correctly.
- **Default divider:** CLK_DIV=5208 with `data`=32'h0000_0055 -> bit width measures 5208 cycles (±0), and a bench 9600-baud receiver at 50 MHz decodes bytes 0x55, 0x00, 0x00, 0x00.
